// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO through its request/valid read port and serializes each byte as a UART frame.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit (8E1); otherwise frames are 8N1.
module fifo_uart_tx #(
    parameter int unsigned CLOCKS_PER_BAUD = 868,
    parameter int unsigned READ_TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_out,
    input  logic       fifo_out_valid,
    input  logic       fifo_empty,
    output logic       fifo_out_req,
    output logic       tx,
    output logic       busy,
    output logic       drop
);
    localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BAUD);
    localparam int unsigned TO_W   = $clog2(READ_TIMEOUT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
    // Drop is registered, so the decision is taken one cycle early to land
    // READ_TIMEOUT cycles after the request pulse.
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(READ_TIMEOUT - 2);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_nxt;
    logic [7:0]        data;
    logic              baud_wrap;
    logic              timeout;
    logic              tx_d;
    logic              req_d;
    logic              busy_d;
    logic              drop_d;

    assign baud_wrap   = (baud_cnt == BAUD_LAST);
    assign timeout     = (to_cnt == TO_LAST);
    assign bit_idx_nxt = (state == DATA && baud_wrap) ? bit_idx + 3'd1 : bit_idx;

    // State register plus output registers fed from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tx           <= 1'b1;
            fifo_out_req <= 1'b0;
            busy         <= 1'b0;
            drop         <= 1'b0;
        end else begin
            state        <= next_state;
            tx           <= tx_d;
            fifo_out_req <= req_d;
            busy         <= busy_d;
            drop         <= drop_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = REQ;
            REQ:     next_state = WAIT;
            WAIT: begin
                if (fifo_out_valid)  next_state = START;
                else if (timeout)    next_state = IDLE;
            end
            START:   if (baud_wrap) next_state = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
            DATA:    if (baud_wrap && bit_idx == 3'd7) next_state = PARITY;
            PARITY:  if (baud_wrap) next_state = STOP;
`else
            DATA:    if (baud_wrap && bit_idx == 3'd7) next_state = STOP;
`endif
            STOP:    if (baud_wrap) next_state = fifo_empty ? IDLE : REQ;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        req_d  = (next_state == REQ);
        busy_d = (next_state != IDLE);
        drop_d = (state == WAIT) && !fifo_out_valid && timeout;
        case (next_state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data[bit_idx_nxt];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = ^data;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            to_cnt   <= '0;
            bit_idx  <= '0;
            data     <= '0;
        end else begin
            case (state)
                IDLE: ;
                REQ:  to_cnt <= '0;
                WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (fifo_out_valid) begin
                        data     <= fifo_out;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                    end
                end
                default: begin
                    baud_cnt <= baud_wrap ? '0 : baud_cnt + BAUD_W'(1);
                    bit_idx  <= bit_idx_nxt;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO read-port model, UART frame decoder and scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int unsigned CPB = 4;
    localparam int unsigned RTO = 15;
    localparam int unsigned LAT = 3;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] fifo_out;
    logic       fifo_out_valid;
    logic       fifo_empty;
    logic       fifo_out_req;
    logic       tx;
    logic       busy;
    logic       drop;

    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;
    int         req_count = 0;
    int         frames_seen = 0;
    int         last_end = 0;
    bit         no_valid = 1'b0;
    bit         mon_armed = 1'b1;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       exp_par_q[$];
    int         gap_q[$];

    fifo_uart_tx #(.CLOCKS_PER_BAUD(CPB), .READ_TIMEOUT(RTO)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_out       (fifo_out),
        .fifo_out_valid (fifo_out_valid),
        .fifo_empty     (fifo_empty),
        .fifo_out_req   (fifo_out_req),
        .tx             (tx),
        .busy           (busy),
        .drop           (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (fifo_out_req === 1'b1) req_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_frame, input logic par);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
        if (expect_frame) begin
            exp_q.push_back(b);
            exp_par_q.push_back(par);
        end
    endtask

    task automatic wait_req(output int rc);
        int unsigned budget = 100;
        @(negedge clk);
        while (fifo_out_req !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("req_seen", fifo_out_req, 1);
        rc = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // FIFO read port: pops on a request and presents the byte LAT cycles later.
    initial begin : fifo_model
        int         cnt;
        bit         pending;
        logic [7:0] held;
        cnt = 0;
        pending = 1'b0;
        held = '0;
        forever begin
            @(posedge clk);
            #1;
            fifo_out_valid = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending = 1'b0;
                    if (!no_valid) begin
                        fifo_out = held;
                        fifo_out_valid = 1'b1;
                    end
                end
            end
            if (fifo_out_req === 1'b1) begin
                check("req_nonempty", 32'(fifo_q.size() != 0), 1);
                if (fifo_q.size() != 0) held = fifo_q.pop_front();
                pending = 1'b1;
                cnt = LAT;
                fifo_empty = (fifo_q.size() == 0);
            end
        end
    end

    // UART decoder: checks each bit is held CPB cycles and compares against the scoreboard.
    initial begin : uart_mon
        logic [10:0] bits;
        logic        lvl;
        logic        exp_par;
        logic [7:0]  exp_b;
        bit          stable;
        int          fstart;
        forever begin
            @(negedge clk);
            if (!rst && mon_armed && tx === 1'b0) begin
                fstart = cyc;
                stable = 1'b1;
                bits = '0;
                lvl = 1'b0;
                for (int unsigned b = 0; b < FRAME_BITS; b++) begin
                    for (int unsigned k = 0; k < CPB; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (k == 0) lvl = tx;
                        else if (tx !== lvl) stable = 1'b0;
                    end
                    bits[b] = lvl;
                end
                gap_q.push_back(fstart - last_end - 1);
                last_end = cyc;
                check("bit_periods_stable", stable, 1);
                check("stop_bit", bits[FRAME_BITS-1], 1);
                check("frame_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    exp_par = exp_par_q.pop_front();
                    check("data_byte", bits[8:1], exp_b);
`ifdef FIFO_UART_TX_PARITY_EN
                    check("parity_bit", bits[9], exp_par);
`endif
                end
                frames_seen++;
            end
        end
    end

    initial begin : main
        int r;
        int p;
        int n0;
        int f0;
        int endc;
        int lowc;
        int busyc;
        int dcount;
        int dcyc;
        rst = 1'b1;
        fifo_out = '0;
        fifo_out_valid = 1'b0;
        fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_req", fifo_out_req, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte 0x55 with 3-cycle read latency.
        n0 = req_count;
        p = cyc;
        push(8'h55, 1'b1, 1'b0);
        wait_req(r);
        check("req_latency", r, p + 1);
        wait_until(r + LAT);
        check("tx_high_before_start", tx, 1);
        wait_until(r + LAT + 1);
        check("start_latency", tx, 0);
        check("busy_in_frame", busy, 1);
        wait_until(r + LAT + FRAME_CYC);
        check("busy_last_stop", busy, 1);
        check("tx_last_stop", tx, 1);
        wait_until(r + LAT + FRAME_CYC + 1);
        check("busy_after_stop", busy, 0);
        check("frames_t1", frames_seen, 1);
        check("reqs_t1", req_count - n0, 1);

        // Three queued bytes go back-to-back with no IDLE cycle.
        gap_q.delete();
        n0 = req_count;
        f0 = frames_seen;
        push(8'hA3, 1'b1, 1'b0);
        push(8'h00, 1'b1, 1'b0);
        push(8'hFF, 1'b1, 1'b0);
        wait_req(r);
        endc = r + LAT + 3 * FRAME_CYC + 2 * (1 + LAT);
        lowc = 0;
        while (cyc < endc) begin
            @(negedge clk);
            if (busy !== 1'b1) lowc++;
        end
        check("no_idle_between_frames", lowc, 0);
        @(negedge clk);
        check("busy_after_burst", busy, 0);
        check("frames_t2", frames_seen - f0, 3);
        check("reqs_t2", req_count - n0, 3);
        check("gap_count", gap_q.size(), 3);
        check("gap_frame2", gap_q[1], 1 + LAT);
        check("gap_frame3", gap_q[2], 1 + LAT);

        // Read that never returns valid times out.
        no_valid = 1'b1;
        f0 = frames_seen;
        push(8'h3C, 1'b0, 1'b0);
        wait_req(r);
        dcount = 0;
        dcyc = 0;
        lowc = 0;
        repeat (RTO + 6) begin
            @(negedge clk);
            if (drop === 1'b1) begin
                dcount++;
                if (dcyc == 0) dcyc = cyc;
            end
            if (tx !== 1'b1) lowc++;
            if (cyc == r + RTO) check("busy_at_drop", busy, 0);
        end
        check("drop_cycle", dcyc, r + RTO);
        check("drop_pulses", dcount, 1);
        check("tx_high_timeout", lowc, 0);
        check("frames_t3", frames_seen - f0, 0);
        no_valid = 1'b0;

        // Reset during data bit 3 of 0xA5 (bit 3 is 0).
        mon_armed = 1'b0;
        push(8'hA5, 1'b0, 1'b0);
        wait_req(r);
        wait_until(r + LAT + 1 + CPB * 4 + 1);
        check("tx_bit3", tx, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n0 = req_count;
        lowc = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) lowc++;
        end
        check("no_rerequest", req_count - n0, 0);
        check("tx_high_after_rst", lowc, 0);
        mon_armed = 1'b1;

        // Spurious valid pulses with the FIFO empty.
        n0 = req_count;
        lowc = 0;
        busyc = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 3 == 0) begin
                fifo_out = 8'hC3;
                fifo_out_valid = 1'b1;
            end
            if (tx !== 1'b1) lowc++;
            if (busy !== 1'b0) busyc++;
        end
        check("spurious_no_req", req_count - n0, 0);
        check("spurious_tx_high", lowc, 0);
        check("spurious_not_busy", busyc, 0);

`ifdef FIFO_UART_TX_PARITY_EN
        gap_q.delete();
        f0 = frames_seen;
        push(8'h07, 1'b1, 1'b1);
        push(8'h03, 1'b1, 1'b0);
        wait_req(r);
        endc = r + LAT + 2 * FRAME_CYC + (1 + LAT);
        wait_until(endc);
        check("parity_last_stop_busy", busy, 1);
        @(negedge clk);
        check("parity_busy_end", busy, 0);
        check("parity_frames", frames_seen - f0, 2);
        check("parity_gap", gap_q.size() > 1 ? gap_q[1] : -1, 1 + LAT);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
